// File: rtl/prio_event_encoder.sv
// rtl/prio_event_encoder.sv - registered N-line priority event encoder with valid/ready output
// Define PENC_ROUND_ROBIN_EN for rotating-pointer selection; fixed priority (index 0 highest) otherwise.
module prio_event_encoder #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req_in,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    out_multi,
    output logic [N-1:0]            pending,
    output logic                    overflow
);

    localparam int IDX_W = $clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]     cand;
    logic             load;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_oh;
    logic             multi;
    logic [N-1:0]     pending_nxt;
    logic             overflow_nxt;

    // Requests bypass the pending register so an idle block issues in one cycle.
    assign cand  = pending | req_in;
    assign load  = (|cand) && (!out_valid || out_ready) && !clr;
    assign multi = |(cand & (cand - ONE_N));

`ifdef PENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    // Scan downward so the first set bit at or above ptr (with wrap) wins.
    always_comb begin
        sel_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (cand[pos]) sel_idx = IDX_W'(pos);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + 1'b1;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) sel_idx = IDX_W'(i);
        end
    end
`endif

    assign sel_oh = load ? (ONE_N << sel_idx) : '0;

    // A line that is pending, re-requested and issued in the same cycle keeps the new event.
    assign pending_nxt  = ((pending | req_in) & ~sel_oh) | (pending & req_in & sel_oh);
    assign overflow_nxt = overflow | (|(req_in & pending & ~sel_oh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_multi <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= sel_idx;
                out_multi <= multi;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr) begin
                pending  <= '0;
                overflow <= 1'b0;
            end else begin
                pending  <= pending_nxt;
                overflow <= overflow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// tb/tb_prio_event_encoder.sv - scoreboard bench for prio_event_encoder
module tb_prio_event_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = '0;
    logic       clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic       out_multi;
    logic [7:0] pending;
    logic       overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [3:0] exp_q[$];   // {multi, idx}

    prio_event_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_multi (out_multi),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] idx, input logic multi);
        exp_q.push_back({multi, idx});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_in = 8'hFF;
        out_ready = 1'b0;
        clr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_valid", {7'd0, out_valid}, 8'h00);
            check("rst_idx", {5'd0, out_idx}, 8'h00);
            check("rst_pending", pending, 8'h00);
            check("rst_overflow", {7'd0, overflow}, 8'h00);
        end
        req_in = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        fork
            forever begin
                logic [3:0] e;
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_event: got idx %0d multi %0d expected none", out_idx, out_multi);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_idx", {5'd0, out_idx}, {5'd0, e[2:0]});
                        check("ev_multi", {7'd0, out_multi}, {7'd0, e[3]});
                    end
                end
            end
        join_none

        do_reset();

        // single event
        tick();
        req_in = 8'h04; out_ready = 1'b1; expect_ev(3'd2, 1'b0);
        tick();
        req_in = 8'h00;
        @(negedge clk);
        check("single_valid", {7'd0, out_valid}, 8'h01);
        check("single_pending", pending, 8'h00);
        tick();
        @(negedge clk);
        check("single_idle", {7'd0, out_valid}, 8'h00);
        check("single_pending2", pending, 8'h00);

        // burst, fixed priority
        tick();
        req_in = 8'h92;
        expect_ev(3'd1, 1'b1); expect_ev(3'd4, 1'b1); expect_ev(3'd7, 1'b0);
        tick();
        req_in = 8'h00;
        @(negedge clk); check("burst_pend1", pending, 8'h90);
        tick();
        @(negedge clk); check("burst_pend2", pending, 8'h80);
        tick();
        @(negedge clk); check("burst_pend3", pending, 8'h00);
        tick();
        @(negedge clk); check("burst_idle", {7'd0, out_valid}, 8'h00);

        // backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        req_in = 8'h01; expect_ev(3'd0, 1'b0);
        tick(); req_in = 8'h00;
        tick(); req_in = 8'h01;
        tick(); req_in = 8'h00;
        tick(); req_in = 8'h01;
        tick(); req_in = 8'h00;
        @(negedge clk);
        check("bp_valid", {7'd0, out_valid}, 8'h01);
        check("bp_idx", {5'd0, out_idx}, 8'h00);
        check("bp_pending", pending, 8'h01);
        check("bp_overflow", {7'd0, overflow}, 8'h01);
        expect_ev(3'd0, 1'b0);
        tick(); out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("bp_drained", {7'd0, out_valid}, 8'h00);
        check("bp_pending_end", pending, 8'h00);

        // clear while an event is held
        do_reset();
        out_ready = 1'b0;
        req_in = 8'h04; expect_ev(3'd2, 1'b0);
        tick(); req_in = 8'h30;
        tick(); req_in = 8'h10;
        tick(); req_in = 8'h00;
        @(negedge clk);
        check("clr_pre_pend", pending, 8'h30);
        check("clr_pre_ovf", {7'd0, overflow}, 8'h01);
        tick(); clr = 1'b1; req_in = 8'h01;
        tick(); clr = 1'b0; req_in = 8'h00;
        @(negedge clk);
        check("clr_pending", pending, 8'h00);
        check("clr_overflow", {7'd0, overflow}, 8'h00);
        check("clr_held_valid", {7'd0, out_valid}, 8'h01);
        check("clr_held_idx", {5'd0, out_idx}, 8'h02);
        tick(); out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("clr_done", {7'd0, out_valid}, 8'h00);

        // selection order after issuing index 5
        do_reset();
        out_ready = 1'b1;
        req_in = 8'h20; expect_ev(3'd5, 1'b0);
        tick(); req_in = 8'h48;
`ifdef PENC_ROUND_ROBIN_EN
        expect_ev(3'd6, 1'b1); expect_ev(3'd3, 1'b0);
`else
        expect_ev(3'd3, 1'b1); expect_ev(3'd6, 1'b0);
`endif
        tick(); req_in = 8'h00;
        repeat (4) tick();
        @(negedge clk);
        check("rr_done", {7'd0, out_valid}, 8'h00);

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
